// File: rtl/parking_time_keeper_pkg.sv
// Shared parameters and time helpers for the parking fee pipeline
// (time keeper, time_calculate and later fee stages).
package parking_time_keeper_pkg;

    localparam int unsigned SLOT_COUNT_DEF = 8;
    localparam int unsigned SLOT_W_DEF     = 3;
    localparam int unsigned TIME_W_DEF     = 8;
    localparam int unsigned TICK_DIV_DEF   = 100;

    typedef logic [TIME_W_DEF-1:0] ptime_t;

    // Modular difference: correct across one wrap of the parking clock.
    function automatic ptime_t time_sub(input ptime_t t_out, input ptime_t t_in);
        return t_out - t_in;
    endfunction

endpackage

// File: rtl/parking_time_base.sv
// Prescaler plus wrapping parking clock; time_now advances once every TICK_DIV cycles.
module parking_time_base
    import parking_time_keeper_pkg::*;
#(
    parameter int unsigned TIME_W   = TIME_W_DEF,
    parameter int unsigned TICK_DIV = TICK_DIV_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic [TIME_W-1:0] time_now_o
);

    localparam int unsigned      PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0]  prescaler_q, prescaler_d;
    logic [TIME_W-1:0] time_q, time_d;

    // Next-state: with TICK_DIV=1 the prescaler sits at its maximum and ticks every cycle.
    always_comb begin
        if (prescaler_q == PRE_MAX) begin
            prescaler_d = '0;
            time_d      = time_q + TIME_W'(1);
        end else begin
            prescaler_d = prescaler_q + PRE_W'(1);
            time_d      = time_q;
        end
    end

    // State registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prescaler_q <= '0;
            time_q      <= '0;
        end else begin
            prescaler_q <= prescaler_d;
            time_q      <= time_d;
        end
    end

    assign time_now_o = time_q;

endmodule

// File: rtl/time_calculate.sv
// Parking duration from the keeper's entry/exit timestamps (mod 2^8).
module time_calculate
    import parking_time_keeper_pkg::*;
(
    input  ptime_t time_in_i,
    input  ptime_t time_out_i,
    output ptime_t time_diff_o
);

    assign time_diff_o = time_sub(time_out_i, time_in_i);

endmodule

// File: rtl/parking_time_keeper.sv
// Parking clock, per-slot entry timestamps and occupancy; presents entry/exit times
// of each departing car for one-cycle consumption by time_calculate.
module parking_time_keeper
    import parking_time_keeper_pkg::*;
#(
    parameter int unsigned SLOT_COUNT = SLOT_COUNT_DEF,
    parameter int unsigned SLOT_W     = SLOT_W_DEF,
    parameter int unsigned TIME_W     = TIME_W_DEF,
    parameter int unsigned TICK_DIV   = TICK_DIV_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  car_enter_i,
    input  logic [SLOT_W-1:0]     enter_slot_i,
    input  logic                  car_exit_i,
    input  logic [SLOT_W-1:0]     exit_slot_i,
    output logic [TIME_W-1:0]     time_now_o,
    output logic [TIME_W-1:0]     time_in_o,
    output logic [TIME_W-1:0]     time_out_o,
    output logic                  diff_valid_o,
    output logic [SLOT_W-1:0]     exit_slot_q_o,
    output logic [SLOT_COUNT-1:0] occupied_o,
    output logic                  full_o,
    output logic                  err_o,
    output logic [TIME_W-1:0]     time_diff_o
);

    localparam logic [SLOT_W:0] SLOT_LIMIT = (SLOT_W + 1)'(SLOT_COUNT);

    logic [TIME_W-1:0]     time_now_s;
    logic                  enter_ok_s, exit_ok_s;
    logic [SLOT_COUNT-1:0] occupied_q, occupied_d;
    logic [TIME_W-1:0]     ts_q [SLOT_COUNT];
    logic [TIME_W-1:0]     ts_d [SLOT_COUNT];
    logic [TIME_W-1:0]     time_in_q, time_in_d, time_out_q, time_out_d;
    logic [SLOT_W-1:0]     exit_slot_q, exit_slot_d;
    logic                  diff_valid_q, diff_valid_d, err_q, err_d, full_q, full_d;

    parking_time_base #(
        .TIME_W   (TIME_W),
        .TICK_DIV (TICK_DIV)
    ) u_time_base (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .time_now_o (time_now_s)
    );

    // Request arbitration: legality is judged on the pre-edge occupancy, so a same-slot
    // enter+exit accepts exactly one of the two and the other raises err.
    always_comb begin
        enter_ok_s = car_enter_i && ({1'b0, enter_slot_i} < SLOT_LIMIT)
                     && !occupied_q[enter_slot_i];
        exit_ok_s  = car_exit_i && ({1'b0, exit_slot_i} < SLOT_LIMIT)
                     && occupied_q[exit_slot_i];
        occupied_d = occupied_q;
        ts_d       = ts_q;
        if (enter_ok_s) begin
            occupied_d[enter_slot_i] = 1'b1;
            ts_d[enter_slot_i]       = time_now_s;
        end else begin
            ts_d = ts_q;
        end
        if (exit_ok_s) begin
            occupied_d[exit_slot_i] = 1'b0;
            time_in_d               = ts_q[exit_slot_i];
            time_out_d              = time_now_s;
            exit_slot_d             = exit_slot_i;
        end else begin
            time_in_d   = time_in_q;
            time_out_d  = time_out_q;
            exit_slot_d = exit_slot_q;
        end
        diff_valid_d = exit_ok_s;
        err_d        = (car_enter_i && !enter_ok_s) || (car_exit_i && !exit_ok_s);
        full_d       = &occupied_d;
    end

    // Output, occupancy and timestamp registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            occupied_q   <= '0;
            time_in_q    <= '0;
            time_out_q   <= '0;
            exit_slot_q  <= '0;
            diff_valid_q <= 1'b0;
            err_q        <= 1'b0;
            full_q       <= 1'b0;
            for (int i = 0; i < SLOT_COUNT; i++) begin
                ts_q[i] <= '0;
            end
        end else begin
            occupied_q   <= occupied_d;
            time_in_q    <= time_in_d;
            time_out_q   <= time_out_d;
            exit_slot_q  <= exit_slot_d;
            diff_valid_q <= diff_valid_d;
            err_q        <= err_d;
            full_q       <= full_d;
            ts_q         <= ts_d;
        end
    end

    time_calculate u_time_calculate (
        .time_in_i   (time_in_q),
        .time_out_i  (time_out_q),
        .time_diff_o (time_diff_o)
    );

    assign time_now_o    = time_now_s;
    assign time_in_o     = time_in_q;
    assign time_out_o    = time_out_q;
    assign diff_valid_o  = diff_valid_q;
    assign exit_slot_q_o = exit_slot_q;
    assign occupied_o    = occupied_q;
    assign full_o        = full_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_parking_time_keeper.sv
// Scoreboard bench: requests push expected pulses, a negedge monitor pops and compares.
module tb_parking_time_keeper;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       car_enter = 1'b0, car_exit = 1'b0;
    logic [2:0] enter_slot = 3'd0, exit_slot = 3'd0;
    logic [7:0] time_now, time_in, time_out, time_diff;
    logic       diff_valid, full, err;
    logic [2:0] exit_slot_q;
    logic [7:0] occupied;

    logic       b_enter = 1'b0, b_exit = 1'b0;
    logic [2:0] b_enter_slot = 3'd0, b_exit_slot = 3'd0;
    logic [7:0] b_time_now, b_time_in, b_time_out, b_time_diff, b_occupied;
    logic       b_diff_valid, b_full, b_err;
    logic [2:0] b_exit_slot_q;

    typedef struct packed {
        logic       v;
        logic       e;
        logic [7:0] tin;
        logic [7:0] tout;
        logic [2:0] slot;
    } exp_t;

    exp_t       sb[$];
    int         compared = 0;
    int         mismatched = 0;
    logic [7:0] mt;

    always #5 clk = ~clk;

    parking_time_keeper #(.TICK_DIV(1)) dut (
        .clk_i(clk), .rst_i(rst),
        .car_enter_i(car_enter), .enter_slot_i(enter_slot),
        .car_exit_i(car_exit), .exit_slot_i(exit_slot),
        .time_now_o(time_now), .time_in_o(time_in), .time_out_o(time_out),
        .diff_valid_o(diff_valid), .exit_slot_q_o(exit_slot_q),
        .occupied_o(occupied), .full_o(full), .err_o(err), .time_diff_o(time_diff)
    );

    parking_time_keeper #(.TICK_DIV(100)) dut_slow (
        .clk_i(clk), .rst_i(rst),
        .car_enter_i(b_enter), .enter_slot_i(b_enter_slot),
        .car_exit_i(b_exit), .exit_slot_i(b_exit_slot),
        .time_now_o(b_time_now), .time_in_o(b_time_in), .time_out_o(b_time_out),
        .diff_valid_o(b_diff_valid), .exit_slot_q_o(b_exit_slot_q),
        .occupied_o(b_occupied), .full_o(b_full), .err_o(b_err), .time_diff_o(b_time_diff)
    );

    // Reference parking clock for TICK_DIV=1.
    always @(posedge clk) begin
        if (rst) mt <= 8'd0;
        else     mt <= mt + 8'd1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: any pulse on diff_valid/err must match the oldest expectation.
    always @(negedge clk) begin
        if (diff_valid === 1'b1 || err === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {30'd0, diff_valid, err}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("diff_valid", {31'd0, diff_valid}, {31'd0, e.v});
                chk("err", {31'd0, err}, {31'd0, e.e});
                if (e.v) begin
                    chk("time_in", {24'd0, time_in}, {24'd0, e.tin});
                    chk("time_out", {24'd0, time_out}, {24'd0, e.tout});
                    chk("exit_slot_q", {29'd0, exit_slot_q}, {29'd0, e.slot});
                end
            end
        end
    end

    task automatic req(input logic en, input logic [2:0] es, input logic ex, input logic [2:0] xs,
                       input logic ev, input logic ee, input logic [7:0] ein,
                       input logic [7:0] eout, input logic [2:0] eslot);
        car_enter  = en;
        enter_slot = es;
        car_exit   = ex;
        exit_slot  = xs;
        if (ev || ee) sb.push_back('{v: ev, e: ee, tin: ein, tout: eout, slot: eslot});
        @(posedge clk);
        @(negedge clk);
        car_enter = 1'b0;
        car_exit  = 1'b0;
    endtask

    task automatic goto_t(input logic [7:0] t);
        int n = 0;
        while (mt !== t && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (mt !== t) chk("goto_timeout", {24'd0, mt}, {24'd0, t});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_time_now", {24'd0, time_now}, 32'd0);
        chk("rst_time_in", {24'd0, time_in}, 32'd0);
        chk("rst_time_out", {24'd0, time_out}, 32'd0);
        chk("rst_flags", {28'd0, diff_valid, err, full, 1'b0}, 32'd0);
        chk("rst_exit_slot_q", {29'd0, exit_slot_q}, 32'd0);
        chk("rst_occupied", {24'd0, occupied}, 32'd0);

        // Time base and wrap
        goto_t(8'd10);
        chk("time_now_10", {24'd0, time_now}, 32'd10);
        goto_t(8'd255);
        chk("time_now_255", {24'd0, time_now}, 32'd255);
        @(negedge clk);
        chk("time_now_wrap", {24'd0, time_now}, 32'd0);

        // Plain stay: slot 2 from 5 to 17
        goto_t(8'd5);
        req(1'b1, 3'd2, 1'b0, 3'd0, 1'b0, 1'b0, 8'd0, 8'd0, 3'd0);
        chk("occ_after_enter2", {24'd0, occupied}, 32'h04);
        goto_t(8'd17);
        req(1'b0, 3'd0, 1'b1, 3'd2, 1'b1, 1'b0, 8'd5, 8'd17, 3'd2);
        chk("occ_after_exit2", {24'd0, occupied}, 32'h00);
        chk("time_diff_12", {24'd0, time_diff}, 32'd12);

        // Stay across the wrap: slot 0 from 250 to 4
        goto_t(8'd250);
        req(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 8'd0, 8'd0, 3'd0);
        goto_t(8'd4);
        req(1'b0, 3'd0, 1'b1, 3'd0, 1'b1, 1'b0, 8'd250, 8'd4, 3'd0);
        chk("time_diff_wrap", {24'd0, time_diff}, 32'd10);

        // Double enter keeps first timestamp; exit from empty slot is rejected
        goto_t(8'd10);
        req(1'b1, 3'd3, 1'b0, 3'd0, 1'b0, 1'b0, 8'd0, 8'd0, 3'd0);
        req(1'b1, 3'd3, 1'b0, 3'd0, 1'b0, 1'b1, 8'd0, 8'd0, 3'd0);
        goto_t(8'd20);
        req(1'b0, 3'd0, 1'b1, 3'd3, 1'b1, 1'b0, 8'd10, 8'd20, 3'd3);
        req(1'b0, 3'd0, 1'b1, 3'd5, 1'b0, 1'b1, 8'd0, 8'd0, 3'd0);
        chk("hold_time_in", {24'd0, time_in}, 32'd10);
        chk("hold_exit_slot", {29'd0, exit_slot_q}, 32'd3);

        // Fill every slot at times 30..37, then swap slot 1 in one cycle
        goto_t(8'd30);
        for (int i = 0; i < 8; i++) begin
            req(1'b1, 3'(i), 1'b0, 3'd0, 1'b0, 1'b0, 8'd0, 8'd0, 3'd0);
        end
        chk("occ_all", {24'd0, occupied}, 32'hFF);
        chk("full_set", {31'd0, full}, 32'd1);
        req(1'b1, 3'd1, 1'b1, 3'd1, 1'b1, 1'b1, 8'd31, 8'd38, 3'd1);
        chk("occ_swap", {24'd0, occupied}, 32'hFD);
        chk("full_clear", {31'd0, full}, 32'd0);

        // Reset while slot 4 exits: request is dropped
        rst       = 1'b1;
        car_exit  = 1'b1;
        exit_slot = 3'd4;
        @(posedge clk);
        @(negedge clk);
        rst      = 1'b0;
        car_exit = 1'b0;
        chk("midrst_occupied", {24'd0, occupied}, 32'd0);
        chk("midrst_flags", {29'd0, diff_valid, err, full}, 32'd0);
        chk("midrst_time_now", {24'd0, time_now}, 32'd0);
        chk("midrst_time_in", {24'd0, time_in}, 32'd0);
        chk("slow_t0", {24'd0, b_time_now}, 32'd0);
        repeat (99) @(negedge clk);
        chk("slow_t99", {24'd0, b_time_now}, 32'd0);
        @(negedge clk);
        chk("slow_t100", {24'd0, b_time_now}, 32'd1);
        repeat (100) @(negedge clk);
        chk("slow_t200", {24'd0, b_time_now}, 32'd2);

        @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
